// File: rtl/e_branch_unit_if.sv
// E-stage branch resolution / BTB interface.
// master : pipeline side (drives the E-stage op and the fetch lookup PC)
// slave  : e_branch_unit (returns resolved PC, misprediction, lookup result, stats)
interface e_branch_unit_if #(
  parameter int unsigned PC_W      = 13,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned NUM_LANES = 2
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                    i_valid;
  logic                    i_flush;
  logic [LANE_W-1:0]       branch_number;
  logic [PC_W-1:0]         pc;
  logic [PC_W-1:0]         pc_predicted;
  logic [PC_W-1:0]         imm;
  logic [32*NUM_LANES-1:0] reg_data1;
  logic [32*NUM_LANES-1:0] reg_data2;
  logic [1:0]              jump_code;
  logic [2:0]              branch_code;
  logic                    o_valid;
  logic [PC_W-1:0]         true_pc;
  logic                    fail_predict;
  logic [PC_W-1:0]         f_pc;
  logic                    f_hit;
  logic                    f_taken;
  logic [PC_W-1:0]         f_target;
  logic [31:0]             miss_count;

  modport master (
    output i_valid, i_flush, branch_number, pc, pc_predicted, imm,
           reg_data1, reg_data2, jump_code, branch_code, f_pc,
    input  o_valid, true_pc, fail_predict, f_hit, f_taken, f_target, miss_count
  );

  modport slave (
    input  i_valid, i_flush, branch_number, pc, pc_predicted, imm,
           reg_data1, reg_data2, jump_code, branch_code, f_pc,
    output o_valid, true_pc, fail_predict, f_hit, f_taken, f_target, miss_count
  );
endinterface

// File: rtl/e_branch_unit.sv
// Execute-stage branch resolver with a direct-mapped BTB (2-bit saturating counters).
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (clears outputs, miss_count, BTB valid bits)
//   bus  - e_branch_unit_if.slave: E-stage op in, registered true_pc/fail_predict/o_valid
//          out, combinational fetch lookup (f_pc -> f_hit/f_taken/f_target), miss_count.
module e_branch_unit #(
  parameter int unsigned PC_W      = 13,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned NUM_LANES = 2
) (
  input logic           clk,
  input logic           rst,
  e_branch_unit_if.slave bus
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned TAG_W  = PC_W - IDX_W;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  logic [31:0]       rs1, rs2;
  logic              flag, taken, go, mispredict;
  logic [PC_W-1:0]   base_pc, jump_pc, pc_inc, true_pc_n;

  logic              btb_valid  [DEPTH];
  logic [TAG_W-1:0]  btb_tag    [DEPTH];
  logic [PC_W-1:0]   btb_target [DEPTH];
  logic [1:0]        btb_ctr    [DEPTH];

  logic [IDX_W-1:0]  u_idx, f_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic [1:0]        ctr_n;

  assign go = bus.i_valid & ~bus.i_flush & (bus.jump_code != 2'b00);

  // Lane mux; any out-of-range lane number falls through to lane 0.
  always_comb begin
    rs1 = bus.reg_data1[31:0];
    rs2 = bus.reg_data2[31:0];
    for (int unsigned k = 1; k < NUM_LANES; k++) begin
      if (bus.branch_number == LANE_W'(k)) begin
        rs1 = bus.reg_data1[32*k +: 32];
        rs2 = bus.reg_data2[32*k +: 32];
      end
    end
  end

  always_comb begin
    flag = 1'b0;
    case (bus.branch_code)
      3'b000:  flag = (rs1 == rs2);
      3'b001:  flag = (rs1 != rs2);
      3'b100:  flag = ($signed(rs1) <  $signed(rs2));
      3'b101:  flag = ($signed(rs1) >= $signed(rs2));
      3'b110:  flag = (rs1 <  rs2);
      3'b111:  flag = (rs1 >= rs2);
      default: flag = 1'b0;
    endcase
  end

  always_comb begin
    base_pc    = (bus.jump_code == 2'b11) ? rs1[PC_W+1:2] : bus.pc;
    jump_pc    = bus.imm + base_pc;
    pc_inc     = bus.pc + PC_W'(1);
    taken      = flag | bus.jump_code[1];
    true_pc_n  = taken ? jump_pc : pc_inc;
    mispredict = bus.jump_code[0] & (true_pc_n != bus.pc_predicted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid      <= 1'b0;
      bus.fail_predict <= 1'b0;
      bus.true_pc      <= '0;
      bus.miss_count   <= '0;
    end else begin
      bus.o_valid      <= go;
      bus.fail_predict <= go & mispredict;
      if (go) bus.true_pc <= true_pc_n;
      if (go && mispredict && (bus.miss_count != '1))
        bus.miss_count <= bus.miss_count + 32'd1;
    end
  end

  // BTB update path
  always_comb begin
    u_idx = bus.pc[IDX_W-1:0];
    u_tag = bus.pc[PC_W-1:IDX_W];
    u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    if (!u_hit)
      ctr_n = taken ? 2'b10 : 2'b01;
    else if (taken)
      ctr_n = (btb_ctr[u_idx] == 2'b11) ? 2'b11 : btb_ctr[u_idx] + 2'b01;
    else
      ctr_n = (btb_ctr[u_idx] == 2'b00) ? 2'b00 : btb_ctr[u_idx] - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) btb_valid[i] <= 1'b0;
    end else if (go) begin
      btb_valid[u_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (go && !rst) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= jump_pc;
      btb_ctr[u_idx]    <= ctr_n;
    end
  end

  // Lookup reads the array directly, so a same-cycle update is not visible yet.
  always_comb begin
    f_idx        = bus.f_pc[IDX_W-1:0];
    bus.f_hit    = btb_valid[f_idx] && (btb_tag[f_idx] == bus.f_pc[PC_W-1:IDX_W]);
    bus.f_taken  = bus.f_hit & btb_ctr[f_idx][1];
    bus.f_target = btb_target[f_idx];
  end
endmodule
